fp_add_sequencer: RTL and testbench
===================================

// Module: fp_add_sequencer
// PURPOSE
// Control FSM for the multi-cycle FP adder datapath (align -> add -> normalize -> round).
// Accepts one operation at a time over a valid/ready handshake.
// Drives one-hot stage enables, including the renormalize pass when rounding carries out.
// Collects per-op status flags; presents the result over a second valid/ready handshake.
// PARAMETERS
// NORM_LIMIT  27  max NORM cycles per op before forced exit to ROUND (sets err)
// CNT_W       16  width of completed-operation counter
// PORTS
// clk         in   1      clock, all state updates on posedge
// res         in   1      synchronous reset, active low
// in_valid    in   1      upstream has an operand pair on the datapath inputs
// in_ready    out  1      sequencer can accept an op (high only in IDLE)
// special_in  in   1      NaN/Inf/zero operand detected; sampled at accept
// sum_zero    in   1      adder result is zero; sampled in ADD
// norm_done   in   1      normalizer MSB is set; sampled every NORM cycle
// round_carry in   1      rounding carried into bit 24; sampled in ROUND
// exp_ovf     in   1      exponent carry (bit 8); sampled in ROUND and RENORM
// en_align    out  1      align-stage enable
// en_add      out  1      mantissa add enable
// en_norm     out  1      normalize one-step enable
// en_round    out  1      rounding-stage enable
// en_renorm   out  1      shift-right-1 / exponent+1 enable
// out_valid   out  1      result and flags are valid
// out_ready   in   1      downstream accepts the result
// overflow    out  1      exponent overflow occurred in this op
// zero        out  1      result is zero (from sum_zero)
// err         out  1      NORM_LIMIT hit, or carry on the second ROUND
// busy        out  1      state != IDLE
// op_cnt      out  CNT_W  completed ops; wraps modulo 2^CNT_W
// BEHAVIOUR
// States: IDLE, ALIGN, ADD, NORM, ROUND, RENORM, DONE. Enables are Moore decodes of state:
//   en_align=ALIGN, en_add=ADD, en_norm=NORM, en_round=ROUND, en_renorm=RENORM.
// Reset (res=0 at posedge): state=IDLE; overflow, zero, err, op_cnt, norm counter and
//   renorm flag all cleared. Gives in_ready=1, busy=0, out_valid=0, all enables=0.
//   Reset mid-op abandons the op; out_valid is never asserted for it.
// IDLE: in_valid & in_ready -> ALIGN. Capture special_in; clear overflow, zero, err,
//   norm counter and renorm flag.
// ALIGN (1 cycle): -> DONE if captured special_in, else -> ADD.
// ADD (1 cycle): sum_zero=1 -> set zero, -> DONE. Otherwise -> NORM.
// NORM: increment norm counter each cycle.
//   norm_done=1 -> ROUND.
//   Counter == NORM_LIMIT-1 without norm_done -> set err, -> ROUND.
//   norm_done wins if both occur in the same cycle (err not set).
// ROUND (1 cycle): exp_ovf=1 -> set overflow (sticky for the op).
//   round_carry=1 and renorm flag clear -> set renorm flag, -> RENORM.
//   round_carry=1 and renorm flag set -> set err, -> DONE.
//   Otherwise -> DONE.
// RENORM (1 cycle): exp_ovf=1 -> set overflow; -> ROUND.
// DONE: out_valid=1; flags held stable.
//   out_ready=1 -> op_cnt+1 (wraps), -> IDLE.
//   out_ready=0 -> stay in DONE.
// in_ready is 0 outside IDLE. No new accept in the same cycle as the DONE handshake,
//   so the minimum op spacing is 1 IDLE cycle.
// Latency, accept edge = cycle 0, N = NORM cycles (>=1):
//   out_valid first high at cycle N+4; N+6 with one RENORM pass.
//   Special-case ops: cycle 2. Zero sum: cycle 3.
// Inputs sampled only in the states listed above; all other cycles ignore them.
// TESTING
// Reset, then in_valid=1 held: accept on first IDLE cycle; en_align, en_add, en_norm,
//   en_round are each high in the expected cycle; norm_done=1 in 1st NORM ->
//   out_valid at cycle 5, all flags 0, op_cnt=1.
// round_carry=1 in first ROUND with exp_ovf=1 in RENORM: sequence ROUND,RENORM,ROUND,DONE;
//   overflow=1, err=0, out_valid at cycle N+6.
// norm_done never asserted, NORM_LIMIT=27: exactly 27 en_norm cycles, then ROUND;
//   err=1 at DONE.
// special_in=1 at accept: out_valid at cycle 2, no en_add/en_norm pulses.
//   sum_zero=1: zero=1 at cycle 3.
// out_ready=0 for 5 cycles in DONE: out_valid and flags held, in_ready=0,
//   op_cnt unchanged until the handshake.
// res=0 while in NORM: next cycle IDLE, in_ready=1, no out_valid.
//   Run 2^CNT_W+1 ops: op_cnt wraps to 1.

Source files
------------

// File: rtl/fp_add_sequencer.sv
// Control FSM for the multi-cycle FP adder datapath.
// The sequence is align -> add -> normalize -> round, with one renormalize pass
// when rounding carries out. Operations arrive over an in_valid/in_ready
// handshake and results leave over an out_valid/out_ready handshake.
module fp_add_sequencer #(
  parameter int NORM_LIMIT = 27,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             special_in,
  input  logic             sum_zero,
  input  logic             norm_done,
  input  logic             round_carry,
  input  logic             exp_ovf,
  output logic             en_align,
  output logic             en_add,
  output logic             en_norm,
  output logic             en_round,
  output logic             en_renorm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             zero,
  output logic             err,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt
);

  // Wide enough to hold NORM_LIMIT itself, so the count never wraps inside one op.
  localparam int NCW = $clog2(NORM_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_RENORM, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic             sp_q;      // special operand captured at accept
  logic             renorm_q;  // one renormalize pass already taken
  logic [NCW-1:0]   ncnt;      // NORM cycles completed for this op
  logic             norm_limit;

  // This NORM cycle is the last one allowed for the op.
  assign norm_limit = (ncnt == NCW'(NORM_LIMIT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!res) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (in_valid) state_nxt = S_ALIGN;
      S_ALIGN:  state_nxt = sp_q ? S_DONE : S_ADD;
      S_ADD:    state_nxt = sum_zero ? S_DONE : S_NORM;
      // norm_done and the limit both lead to ROUND; only the limit sets err.
      S_NORM:   if (norm_done || norm_limit) state_nxt = S_ROUND;
      S_ROUND:  state_nxt = (round_carry && !renorm_q) ? S_RENORM : S_DONE;
      S_RENORM: state_nxt = S_ROUND;
      S_DONE:   if (out_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Per-op status flags, norm counter and completed-op counter.
  always_ff @(posedge clk) begin
    if (!res) begin
      sp_q     <= 1'b0;
      renorm_q <= 1'b0;
      ncnt     <= '0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      err      <= 1'b0;
      op_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          sp_q     <= special_in;
          renorm_q <= 1'b0;
          ncnt     <= '0;
          overflow <= 1'b0;
          zero     <= 1'b0;
          err      <= 1'b0;
        end
        S_ADD: if (sum_zero) zero <= 1'b1;
        S_NORM: begin
          ncnt <= ncnt + NCW'(1);
          if (!norm_done && norm_limit) err <= 1'b1;
        end
        S_ROUND: begin
          if (exp_ovf) overflow <= 1'b1;
          // A second carry out means renormalizing did not settle the result.
          if (round_carry) begin
            if (renorm_q) err      <= 1'b1;
            else          renorm_q <= 1'b1;
          end
        end
        S_RENORM: if (exp_ovf) overflow <= 1'b1;
        S_DONE: if (out_ready) op_cnt <= op_cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Moore decodes of state.
  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);
  assign en_align  = (state == S_ALIGN);
  assign en_add    = (state == S_ADD);
  assign en_norm   = (state == S_NORM);
  assign en_round  = (state == S_ROUND);
  assign en_renorm = (state == S_RENORM);

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed self-checking bench for fp_add_sequencer.
// Inputs change 1ns after posedge; outputs are checked at that same point.
module tb_fp_add_sequencer;
  localparam int NL = 27;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          res = 1'b0;
  logic          in_valid = 1'b0, special_in = 1'b0, sum_zero = 1'b0;
  logic          norm_done = 1'b0, round_carry = 1'b0, exp_ovf = 1'b0, out_ready = 1'b0;
  logic          in_ready, en_align, en_add, en_norm, en_round, en_renorm;
  logic          out_valid, overflow, zero, err, busy;
  logic [CW-1:0] op_cnt;

  int checks = 0;
  int errors = 0;

  fp_add_sequencer #(.NORM_LIMIT(NL), .CNT_W(CW)) dut (
    .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready),
    .special_in(special_in), .sum_zero(sum_zero), .norm_done(norm_done),
    .round_carry(round_carry), .exp_ovf(exp_ovf), .en_align(en_align),
    .en_add(en_add), .en_norm(en_norm), .en_round(en_round), .en_renorm(en_renorm),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow),
    .zero(zero), .err(err), .busy(busy), .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reactive driver: accepts one op from IDLE and answers each stage's inputs
  // until out_valid (or a 100-cycle bound). lat counts from the accept cycle = 0.
  task automatic run_op(input bit sp, input bit sz, input int nd_at,
                        input bit c1, input bit c2, input bit ov_r1, input bit ov_rn,
                        output int lat, output int n_add, output int n_norm,
                        output int n_round, output int n_renorm);
    int cyc, nn, nr;
    lat = -1; n_add = 0; n_norm = 0; n_round = 0; n_renorm = 0;
    nn = 0; nr = 0;
    special_in = sp; in_valid = 1'b1;
    tick;
    in_valid = 1'b0; special_in = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      sum_zero = 1'b0; norm_done = 1'b0; round_carry = 1'b0; exp_ovf = 1'b0;
      if (en_add) begin n_add++; sum_zero = sz; end
      if (en_norm) begin n_norm++; nn++; norm_done = (nn == nd_at); end
      if (en_round) begin
        n_round++; nr++;
        round_carry = (nr == 1) ? c1 : c2;
        exp_ovf     = (nr == 1) ? ov_r1 : 1'b0;
      end
      if (en_renorm) begin n_renorm++; exp_ovf = ov_rn; end
      tick;
      cyc++;
    end
    sum_zero = 1'b0; norm_done = 1'b0; round_carry = 1'b0; exp_ovf = 1'b0;
    if (out_valid) lat = cyc;
  endtask

  task automatic ack;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    res = 1'b0;
    tick; tick;
    checks++;
    if ({in_ready, busy, out_valid, en_align, en_add, en_norm, en_round, en_renorm} !== 8'b1000_0000) begin
      errors++; $display("FAIL reset_ctrl got %b want 10000000",
        {in_ready, busy, out_valid, en_align, en_add, en_norm, en_round, en_renorm});
    end
    checks++;
    if ({overflow, zero, err} !== 3'b000 || op_cnt !== 0) begin
      errors++; $display("FAIL reset_flags got ovf/zero/err=%b cnt=%0d want 000 cnt=0", {overflow, zero, err}, op_cnt);
    end
    res = 1'b1;
    tick;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle got in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  // Cycle-by-cycle walk of a plain op with norm_done in the first NORM cycle.
  task automatic test_basic;
    in_valid = 1'b1;  // cycle 0 (IDLE)
    tick;             // cycle 1
    in_valid = 1'b0;
    checks++;
    if ({en_align, en_add, in_ready, busy} !== 4'b1001) begin
      errors++; $display("FAIL basic_c1 got align/add/rdy/busy=%b want 1001", {en_align, en_add, in_ready, busy});
    end
    tick;             // cycle 2
    checks++;
    if ({en_align, en_add, en_norm} !== 3'b010) begin
      errors++; $display("FAIL basic_c2 got align/add/norm=%b want 010", {en_align, en_add, en_norm});
    end
    tick;             // cycle 3
    norm_done = 1'b1;
    checks++;
    if ({en_add, en_norm, en_round} !== 3'b010) begin
      errors++; $display("FAIL basic_c3 got add/norm/round=%b want 010", {en_add, en_norm, en_round});
    end
    tick;             // cycle 4
    norm_done = 1'b0;
    checks++;
    if ({en_norm, en_round, out_valid} !== 3'b010) begin
      errors++; $display("FAIL basic_c4 got norm/round/valid=%b want 010", {en_norm, en_round, out_valid});
    end
    tick;             // cycle 5
    checks++;
    if (out_valid !== 1'b1 || {overflow, zero, err} !== 3'b000 || en_round !== 1'b0) begin
      errors++; $display("FAIL basic_c5 got valid=%b flags=%b round=%b want 1 000 0", out_valid, {overflow, zero, err}, en_round);
    end
    ack;
    checks++;
    if (op_cnt !== 1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_cnt got cnt=%0d rdy=%b want 1 1", op_cnt, in_ready);
    end
  endtask

  // Carry in first ROUND, overflow in RENORM; then held in DONE for 5 cycles.
  task automatic test_renorm_stall;
    int lat, na, nn, nr, nrn;
    logic [CW-1:0] cnt0;
    cnt0 = op_cnt;
    run_op(0, 0, 1, 1, 0, 0, 1, lat, na, nn, nr, nrn);
    checks++;
    if (lat !== 7 || nr !== 2 || nrn !== 1) begin
      errors++; $display("FAIL renorm_seq got lat=%0d rounds=%0d renorms=%0d want 7 2 1", lat, nr, nrn);
    end
    checks++;
    if (overflow !== 1'b1 || err !== 1'b0 || zero !== 1'b0) begin
      errors++; $display("FAIL renorm_flags got ovf=%b err=%b zero=%b want 1 0 0", overflow, err, zero);
    end
    in_valid = 1'b1;  // must not be accepted while DONE is stalled
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || overflow !== 1'b1 || err !== 1'b0 || op_cnt !== cnt0) begin
        errors++; $display("FAIL stall_%0d got valid=%b rdy=%b ovf=%b err=%b cnt=%0d want 1 0 1 0 %0d",
          i, out_valid, in_ready, overflow, err, op_cnt, cnt0);
      end
    end
    in_valid = 1'b0;
    ack;
    checks++;
    if (op_cnt !== cnt0 + 8'd1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release got cnt=%0d valid=%b rdy=%b want %0d 0 1", op_cnt, out_valid, in_ready, cnt0 + 8'd1);
    end
  endtask

  task automatic test_norm_limit;
    int lat, na, nn, nr, nrn;
    run_op(0, 0, 0, 0, 0, 0, 0, lat, na, nn, nr, nrn);
    checks++;
    if (nn !== NL || lat !== NL + 4 || err !== 1'b1 || nr !== 1) begin
      errors++; $display("FAIL norm_limit got norms=%0d lat=%0d err=%b rounds=%0d want %0d %0d 1 1", nn, lat, err, nr, NL, NL + 4);
    end
    ack;
    // norm_done on the very last permitted cycle wins over the limit.
    run_op(0, 0, NL, 0, 0, 0, 0, lat, na, nn, nr, nrn);
    checks++;
    if (nn !== NL || lat !== NL + 4 || err !== 1'b0) begin
      errors++; $display("FAIL norm_edge got norms=%0d lat=%0d err=%b want %0d %0d 0", nn, lat, err, NL, NL + 4);
    end
    ack;
  endtask

  task automatic test_round_cases;
    int lat, na, nn, nr, nrn;
    run_op(0, 0, 3, 1, 1, 0, 0, lat, na, nn, nr, nrn);
    checks++;
    if (lat !== 9 || nr !== 2 || nrn !== 1 || err !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL double_carry got lat=%0d rounds=%0d renorms=%0d err=%b ovf=%b want 9 2 1 1 0", lat, nr, nrn, err, overflow);
    end
    ack;
    run_op(0, 0, 2, 0, 0, 1, 0, lat, na, nn, nr, nrn);
    checks++;
    if (lat !== 6 || overflow !== 1'b1 || err !== 1'b0 || nrn !== 0) begin
      errors++; $display("FAIL round_ovf got lat=%0d ovf=%b err=%b renorms=%0d want 6 1 0 0", lat, overflow, err, nrn);
    end
    ack;
  endtask

  task automatic test_special_zero;
    int lat, na, nn, nr, nrn;
    run_op(1, 1, 1, 0, 0, 0, 0, lat, na, nn, nr, nrn);
    checks++;
    if (lat !== 2 || na !== 0 || nn !== 0 || nr !== 0 || zero !== 1'b0) begin
      errors++; $display("FAIL special got lat=%0d adds=%0d norms=%0d rounds=%0d zero=%b want 2 0 0 0 0", lat, na, nn, nr, zero);
    end
    ack;
    run_op(0, 1, 1, 0, 0, 0, 0, lat, na, nn, nr, nrn);
    checks++;
    if (lat !== 3 || zero !== 1'b1 || na !== 1 || nn !== 0) begin
      errors++; $display("FAIL zero_sum got lat=%0d zero=%b adds=%0d norms=%0d want 3 1 1 0", lat, zero, na, nn);
    end
    ack;
    // Flags from the previous op are cleared at the next accept.
    run_op(0, 0, 1, 0, 0, 0, 0, lat, na, nn, nr, nrn);
    checks++;
    if (lat !== 5 || zero !== 1'b0) begin
      errors++; $display("FAIL flag_clear got lat=%0d zero=%b want 5 0", lat, zero);
    end
    ack;
  endtask

  task automatic test_back_to_back;
    logic [CW-1:0] cnt0;
    cnt0 = op_cnt;
    in_valid = 1'b1; special_in = 1'b1; out_ready = 1'b1;
    tick; tick;  // ALIGN, DONE
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_done got valid=%b want 1", out_valid);
    end
    tick;        // handshake -> IDLE, no same-cycle accept
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || op_cnt !== cnt0 + 8'd1) begin
      errors++; $display("FAIL b2b_gap got rdy=%b busy=%b cnt=%0d want 1 0 %0d", in_ready, busy, op_cnt, cnt0 + 8'd1);
    end
    tick;
    checks++;
    if (en_align !== 1'b1) begin
      errors++; $display("FAIL b2b_accept got align=%b want 1", en_align);
    end
    in_valid = 1'b0; special_in = 1'b0;
    tick; tick;  // DONE, handshake
    out_ready = 1'b0;
    checks++;
    if (op_cnt !== cnt0 + 8'd2 || in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_cnt got cnt=%0d rdy=%b want %0d 1", op_cnt, in_ready, cnt0 + 8'd2);
    end
  endtask

  task automatic test_reset_mid;
    in_valid = 1'b1;
    tick; in_valid = 1'b0;
    tick; tick;  // ADD, NORM
    checks++;
    if (en_norm !== 1'b1) begin
      errors++; $display("FAIL midrst_norm got norm=%b want 1", en_norm);
    end
    res = 1'b0;
    tick;
    res = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || en_norm !== 1'b0 || op_cnt !== 0) begin
      errors++; $display("FAIL midrst got rdy=%b valid=%b norm=%b cnt=%0d want 1 0 0 0", in_ready, out_valid, en_norm, op_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL midrst_quiet got valid=%b busy=%b want 0 0", out_valid, busy);
      end
    end
  endtask

  // Special ops take 3 cycles each with out_ready held high.
  task automatic test_wrap;
    res = 1'b0; tick; res = 1'b1;
    in_valid = 1'b1; special_in = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < (1 << CW); i++) begin
      tick; tick; tick;
    end
    checks++;
    if (op_cnt !== 0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL wrap_zero got cnt=%0d rdy=%b want 0 1", op_cnt, in_ready);
    end
    tick; tick; tick;
    in_valid = 1'b0; special_in = 1'b0; out_ready = 1'b0;
    checks++;
    if (op_cnt !== 1) begin
      errors++; $display("FAIL wrap_one got cnt=%0d want 1", op_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_renorm_stall;
    test_norm_limit;
    test_round_cases;
    test_special_zero;
    test_back_to_back;
    test_reset_mid;
    test_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
